// File: rtl/rv16_dmem_responder_pkg.sv
// Shared types and helpers for the RV16 data-memory responder: funct3 size
// decode, FSM states, and store lane/byte-enable helpers.
package rv16_mem_pkg;

   localparam int WAIT_CNT_W = 4;

   typedef enum logic [2:0] {
      MEM_B  = 3'b000,
      MEM_H  = 3'b001,
      MEM_W  = 3'b010,
      MEM_BU = 3'b100,
      MEM_HU = 3'b101
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } dmem_state_e;

   // Reserved encodings 011/110/111 collapse onto a full-word access.
   function automatic mem_size_e decode_size(logic [2:0] funct3);
      case (funct3)
         3'b000:  return MEM_B;
         3'b001:  return MEM_H;
         3'b100:  return MEM_BU;
         3'b101:  return MEM_HU;
         default: return MEM_W;
      endcase
   endfunction

   function automatic logic misaligned(mem_size_e size, logic [1:0] lane);
      case (size)
         MEM_H, MEM_HU: return lane[0];
         MEM_W:         return |lane;
         default:       return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] store_be(mem_size_e size, logic [1:0] lane);
      case (size)
         MEM_B, MEM_BU: return 4'b0001 << lane;
         MEM_H, MEM_HU: return lane[1] ? 4'b1100 : 4'b0011;
         default:       return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_data(mem_size_e size, logic [31:0] wdata);
      case (size)
         MEM_B, MEM_BU: return {4{wdata[7:0]}};
         MEM_H, MEM_HU: return {2{wdata[15:0]}};
         default:       return wdata;
      endcase
   endfunction

endpackage

// File: rtl/rv16_dmem_responder_if.sv
// Execute-stage memory port bundle; master is the execute stage, slave the responder.
interface rv16_dmem_responder_if;

   logic [31:0] i_mem_addr;
   logic [31:0] i_mem_wdata;
   logic        i_mem_read;
   logic        i_mem_write;
   logic [2:0]  i_mem_size;
   logic [31:0] o_mem_rdata;
   logic        o_mem_ready;
   logic        o_mem_err;

   modport master (
      output i_mem_addr, i_mem_wdata, i_mem_read, i_mem_write, i_mem_size,
      input  o_mem_rdata, o_mem_ready, o_mem_err
   );

   modport slave (
      input  i_mem_addr, i_mem_wdata, i_mem_read, i_mem_write, i_mem_size,
      output o_mem_rdata, o_mem_ready, o_mem_err
   );

endinterface

// File: rtl/rv16_dmem_responder_extend.sv
// Load path: picks the addressed byte/half out of a memory word and sign- or
// zero-extends it; halves use lane[1] only, words ignore the lane.
module rv16_dmem_extend
   import rv16_mem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  lane_i,
   input  mem_size_e   size_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (lane_i)
         2'd0:    byte_sel = word_i[7:0];
         2'd1:    byte_sel = word_i[15:8];
         2'd2:    byte_sel = word_i[23:16];
         default: byte_sel = word_i[31:24];
      endcase
      half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

      case (size_i)
         MEM_B:   data_o = {{24{byte_sel[7]}}, byte_sel};
         MEM_BU:  data_o = {24'd0, byte_sel};
         MEM_H:   data_o = {{16{half_sel[15]}}, half_sel};
         MEM_HU:  data_o = {16'd0, half_sel};
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/rv16_dmem_responder.sv
// RV16 data-memory responder: IDLE/WAIT/RESP handshake FSM over a word SRAM model.
// Define RV16_DMEM_MISALIGN_ERR_EN to flag (and suppress) misaligned accesses.
module rv16_dmem_responder
   import rv16_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   rv16_dmem_responder_if.slave  mem
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned AW    = IDX_W + 2;
   localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

   dmem_state_e           state_q, state_d;
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]         addr_q, addr_d;
   mem_size_e             size_q, size_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  write_q, write_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic [31:0]           mem_q [DEPTH_WORDS];

   logic [AW-1:0]         acc_addr;
   mem_size_e             acc_size;
   logic                  acc_write;
   logic                  acc_misalign;
   logic [31:0]           acc_word;
   logic [31:0]           ext_data;
   logic [3:0]            wr_be;
   logic [31:0]           wr_data;
   logic                  unused_addr_hi;

   // Address bits above the array are dropped, so accesses wrap modulo depth.
   assign unused_addr_hi = ^mem.i_mem_addr[31:AW];

   // In IDLE the live inputs describe the access; afterwards only the captured copy.
   always_comb begin
      acc_addr  = addr_q;
      acc_size  = size_q;
      acc_write = write_q;
      if (state_q == ST_IDLE) begin
         acc_addr  = mem.i_mem_addr[AW-1:0];
         acc_size  = decode_size(mem.i_mem_size);
         acc_write = mem.i_mem_write;
      end
   end

   assign acc_word = mem_q[acc_addr[AW-1:2]];

`ifdef RV16_DMEM_MISALIGN_ERR_EN
   assign acc_misalign = misaligned(acc_size, acc_addr[1:0]);
`else
   assign acc_misalign = 1'b0;
`endif

   rv16_dmem_extend u_extend (
      .word_i (acc_word),
      .lane_i (acc_addr[1:0]),
      .size_i (acc_size),
      .data_o (ext_data)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      size_d  = size_q;
      wdata_d = wdata_q;
      write_d = write_q;
      rdata_d = rdata_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            if (mem.i_mem_read || mem.i_mem_write) begin
               addr_d  = acc_addr;
               size_d  = acc_size;
               wdata_d = mem.i_mem_wdata;
               write_d = acc_write;
               cnt_d   = WAIT_INIT;
               state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == WAIT_CNT_W'(1)) state_d = ST_RESP;
         end
         default: state_d = ST_IDLE;
      endcase

      // Response data is registered on the edge entering RESP and held until the next one.
      if (state_d == ST_RESP) begin
         rdata_d = (acc_write || acc_misalign) ? 32'd0 : ext_data;
         err_d   = acc_misalign;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         size_q  <= MEM_B;
         wdata_q <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign wr_be   = store_be(size_q, addr_q[1:0]);
   assign wr_data = store_data(size_q, wdata_q);

   // NOTE: the array has no reset; a reset would turn the SRAM model into a flop bank.
   always_ff @(posedge clk) begin
      if (state_q == ST_RESP && write_q && !err_q) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) mem_q[addr_q[AW-1:2]][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   assign mem.o_mem_ready = (state_q == ST_RESP);
   assign mem.o_mem_rdata = rdata_q;
`ifdef RV16_DMEM_MISALIGN_ERR_EN
   assign mem.o_mem_err   = err_q;
`else
   assign mem.o_mem_err   = 1'b0;
`endif

endmodule

// File: tb/tb_rv16_dmem_responder.sv
// Directed bench for rv16_dmem_responder: one zero-wait and one 3-wait-state
// instance share clock and reset; expectations follow RV16_DMEM_MISALIGN_ERR_EN.
module tb_rv16_dmem_responder;
   import rv16_mem_pkg::*;

`ifdef RV16_DMEM_MISALIGN_ERR_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [31:0] a;
      logic [31:0] wd;
      logic [2:0]  sz;
      logic [31:0] exp;
      logic        exp_err;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic        rd_r    [2];
   logic        wr_r    [2];
   logic [31:0] addr_r  [2];
   logic [31:0] wdata_r [2];
   logic [2:0]  size_r  [2];
   logic        ready_w [2];
   logic        err_w   [2];
   logic [31:0] rdata_w [2];

   rv16_dmem_responder_if if0 ();
   rv16_dmem_responder_if if3 ();

   assign if0.i_mem_read  = rd_r[0];
   assign if0.i_mem_write = wr_r[0];
   assign if0.i_mem_addr  = addr_r[0];
   assign if0.i_mem_wdata = wdata_r[0];
   assign if0.i_mem_size  = size_r[0];
   assign if3.i_mem_read  = rd_r[1];
   assign if3.i_mem_write = wr_r[1];
   assign if3.i_mem_addr  = addr_r[1];
   assign if3.i_mem_wdata = wdata_r[1];
   assign if3.i_mem_size  = size_r[1];
   assign ready_w[0] = if0.o_mem_ready;
   assign rdata_w[0] = if0.o_mem_rdata;
   assign err_w[0]   = if0.o_mem_err;
   assign ready_w[1] = if3.o_mem_ready;
   assign rdata_w[1] = if3.o_mem_rdata;
   assign err_w[1]   = if3.o_mem_err;

   rv16_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
      .clk (clk), .rst_n (rst_n), .mem (if0)
   );
   rv16_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut3 (
      .clk (clk), .rst_n (rst_n), .mem (if3)
   );

   function automatic vec_t mk(logic rd, logic wr, logic [31:0] a, logic [31:0] wd,
                               logic [2:0] sz, logic [31:0] exp, logic exp_err);
      vec_t v;
      v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.sz = sz; v.exp = exp; v.exp_err = exp_err;
      return v;
   endfunction

   // One held request on DUT d; returns edges-to-ready, then checks the pulse
   // drops and rdata holds in the following (IDLE) cycle.
   task automatic access(input int d, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] sz,
                         output int lat, output logic [31:0] rdata, output logic err);
      @(negedge clk);
      rd_r[d] = rd; wr_r[d] = wr; addr_r[d] = a; wdata_r[d] = wd; size_r[d] = sz;
      lat = -1; rdata = 'x; err = 1'bx;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (ready_w[d] === 1'b1) begin
            lat = c; rdata = rdata_w[d]; err = err_w[d];
            break;
         end
      end
      rd_r[d] = 1'b0; wr_r[d] = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (ready_w[d] !== 1'b0) begin
         n_fail++; $display("FAIL ready_single_pulse dut%0d addr %h: got %b expected 0", d, a, ready_w[d]);
      end
      n_checks++;
      if (rdata_w[d] !== rdata) begin
         n_fail++; $display("FAIL rdata_hold dut%0d addr %h: got %h expected %h", d, a, rdata_w[d], rdata);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (ready_w[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ready dut%0d: got %b expected 0", d, ready_w[d]); end
         n_checks++;
         if (rdata_w[d] !== 32'd0) begin n_fail++; $display("FAIL reset_rdata dut%0d: got %h expected 0", d, rdata_w[d]); end
         n_checks++;
         if (err_w[d] !== 1'b0) begin n_fail++; $display("FAIL reset_err dut%0d: got %b expected 0", d, err_w[d]); end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Runs a table against one DUT, checking latency, data and error flag per entry.
   task automatic run_table(input string tag, input int d, input int exp_lat, input vec_t v[8], input int n);
      int lat; logic [31:0] rdata; logic err;
      for (int i = 0; i < n; i++) begin
         access(d, v[i].rd, v[i].wr, v[i].a, v[i].wd, v[i].sz, lat, rdata, err);
         n_checks++;
         if (lat !== exp_lat) begin n_fail++; $display("FAIL %s[%0d]_latency: got %0d expected %0d", tag, i, lat, exp_lat); end
         n_checks++;
         if (rdata !== v[i].exp) begin n_fail++; $display("FAIL %s[%0d]_rdata: got %h expected %h", tag, i, rdata, v[i].exp); end
         n_checks++;
         if (err !== v[i].exp_err) begin n_fail++; $display("FAIL %s[%0d]_err: got %b expected %b", tag, i, err, v[i].exp_err); end
      end
   endtask

   task automatic test_word_rw();
      vec_t v[8];
      v[0] = mk(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, MEM_W, 32'h0,        1'b0);
      v[1] = mk(1'b1, 1'b0, 32'h10, 32'h0,        MEM_W, 32'hDEADBEEF, 1'b0);
      run_table("word_rw", 0, 1, v, 2);
   endtask

   task automatic test_byte();
      vec_t v[8];
      v[0] = mk(1'b1, 1'b0, 32'h13, 32'h0,  MEM_B,  32'hFFFFFFDE, 1'b0);
      v[1] = mk(1'b1, 1'b0, 32'h13, 32'h0,  MEM_BU, 32'h000000DE, 1'b0);
      v[2] = mk(1'b0, 1'b1, 32'h11, 32'h55, MEM_B,  32'h0,        1'b0);
      v[3] = mk(1'b1, 1'b0, 32'h10, 32'h0,  MEM_W,  32'hDEAD55EF, 1'b0);
      v[4] = mk(1'b1, 1'b0, 32'h10, 32'h0,  MEM_H,  32'h000055EF, 1'b0);
      v[5] = mk(1'b1, 1'b0, 32'h10, 32'h0,  MEM_B,  32'hFFFFFFEF, 1'b0);
      run_table("byte", 0, 1, v, 6);
   endtask

   task automatic test_half_wait_wrap();
      vec_t v[8];
      v[0] = mk(1'b0, 1'b1, 32'h10,   32'hDEADBEEF, MEM_W,  32'h0,        1'b0);
      v[1] = mk(1'b1, 1'b0, 32'h12,   32'h0,        MEM_H,  32'hFFFFDEAD, 1'b0);
      v[2] = mk(1'b1, 1'b0, 32'h10,   32'h0,        MEM_HU, 32'h0000BEEF, 1'b0);
      v[3] = mk(1'b1, 1'b0, 32'h1010, 32'h0,        MEM_W,  32'hDEADBEEF, 1'b0);
      v[4] = mk(1'b0, 1'b1, 32'h1014, 32'h0BADF00D, MEM_W,  32'h0,        1'b0);
      v[5] = mk(1'b1, 1'b0, 32'h14,   32'h0,        MEM_W,  32'h0BADF00D, 1'b0);
      v[6] = mk(1'b1, 1'b0, 32'h10,   32'h0,        3'b111, 32'hDEADBEEF, 1'b0);
      v[7] = mk(1'b1, 1'b0, 32'h10,   32'h0,        MEM_H,  32'hFFFFBEEF, 1'b0);
      run_table("half_wait", 1, 4, v, 8);
   endtask

   // Word 0x10 holds 0xDEAD55EF on the zero-wait instance at this point.
   task automatic test_misalign();
      vec_t v[8];
      v[0] = mk(1'b0, 1'b1, 32'h11, 32'h1234, MEM_H,  32'h0, MIS_EN);
      v[1] = mk(1'b1, 1'b0, 32'h10, 32'h0,    MEM_W,  MIS_EN ? 32'hDEAD55EF : 32'hDEAD1234, 1'b0);
      v[2] = mk(1'b1, 1'b0, 32'h12, 32'h0,    MEM_W,  MIS_EN ? 32'h0 : 32'hDEAD1234, MIS_EN);
      v[3] = mk(1'b1, 1'b0, 32'h13, 32'h0,    MEM_HU, MIS_EN ? 32'h0 : 32'h0000DEAD, MIS_EN);
      v[4] = mk(1'b1, 1'b0, 32'h13, 32'h0,    MEM_B,  32'hFFFFFFDE, 1'b0);
      run_table("misalign", 0, 1, v, 5);
   endtask

   task automatic test_rw_both();
      vec_t v[8];
      v[0] = mk(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, MEM_W, 32'h0,        1'b0);
      v[1] = mk(1'b1, 1'b0, 32'h20, 32'h0,        MEM_W, 32'hCAFEF00D, 1'b0);
      run_table("rw_both", 0, 1, v, 2);
   endtask

   // Request held for only the accepting edge; the bus then carries junk.
   task automatic test_dropped();
      int lat; logic [31:0] rdata; logic err;
      vec_t v[8];
      @(negedge clk);
      wr_r[1] = 1'b1; rd_r[1] = 1'b0; addr_r[1] = 32'h24; wdata_r[1] = 32'h13579BDF; size_r[1] = MEM_W;
      @(posedge clk); #1;
      wr_r[1] = 1'b0; addr_r[1] = 32'h2C; wdata_r[1] = 32'hFFFFFFFF; size_r[1] = MEM_B;
      lat = -1;
      for (int c = 2; c <= 20; c++) begin
         @(posedge clk); #1;
         if (ready_w[1] === 1'b1) begin lat = c; rdata = rdata_w[1]; break; end
      end
      n_checks++;
      if (lat !== 4) begin n_fail++; $display("FAIL dropped_store_latency: got %0d expected 4", lat); end
      n_checks++;
      if (rdata !== 32'h0) begin n_fail++; $display("FAIL dropped_store_rdata: got %h expected 0", rdata); end
      @(posedge clk); #1;
      access(1, 1'b1, 1'b0, 32'h24, 32'h0, MEM_W, lat, rdata, err);
      n_checks++;
      if (rdata !== 32'h13579BDF) begin n_fail++; $display("FAIL dropped_store_commit: got %h expected 13579bdf", rdata); end
      v[0] = mk(1'b0, 1'b1, 32'h2C, 32'hA5A5A5A5, MEM_W, 32'h0,        1'b0);
      v[1] = mk(1'b1, 1'b0, 32'h2C, 32'h0,        MEM_B, 32'hFFFFFFA5, 1'b0);
      run_table("after_drop", 1, 4, v, 2);
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] rdata; logic err;
      int seen;
      vec_t v[8];
      v[0] = mk(1'b0, 1'b1, 32'h28, 32'h11111111, MEM_W, 32'h0,        1'b0);
      v[1] = mk(1'b1, 1'b0, 32'h28, 32'h0,        MEM_W, 32'h11111111, 1'b0);
      run_table("pre_reset", 1, 4, v, 2);
      @(negedge clk);
      wr_r[1] = 1'b1; addr_r[1] = 32'h28; wdata_r[1] = 32'h22222222; size_r[1] = MEM_W;
      @(posedge clk); #1;
      wr_r[1] = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (ready_w[1] !== 1'b0) begin n_fail++; $display("FAIL midreset_ready: got %b expected 0", ready_w[1]); end
      n_checks++;
      if (rdata_w[1] !== 32'h0) begin n_fail++; $display("FAIL midreset_rdata: got %h expected 0", rdata_w[1]); end
      n_checks++;
      if (err_w[1] !== 1'b0) begin n_fail++; $display("FAIL midreset_err: got %b expected 0", err_w[1]); end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (ready_w[1] !== 1'b0) seen++;
      end
      n_checks++;
      if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_ready: got %0d pulses expected 0", seen); end
      access(1, 1'b1, 1'b0, 32'h28, 32'h0, MEM_W, lat, rdata, err);
      n_checks++;
      if (lat !== 4) begin n_fail++; $display("FAIL postreset_latency: got %0d expected 4", lat); end
      n_checks++;
      if (rdata !== 32'h11111111) begin n_fail++; $display("FAIL postreset_store_discarded: got %h expected 11111111", rdata); end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rd_r[d] = 1'b0; wr_r[d] = 1'b0; addr_r[d] = '0; wdata_r[d] = '0; size_r[d] = MEM_W;
      end
      test_reset();
      test_word_rw();
      test_byte();
      test_half_wait_wrap();
      test_misalign();
      test_rw_both();
      test_dropped();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
